// File: rtl/serial_word_tx.sv
// serial_word_tx: LSB-first parallel-to-serial word transmitter with a frame-start marker
module serial_word_tx #(
  parameter int WIDTH = 8,
  parameter int GAP = 0
) (
  input  logic             t_clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_i,
  output logic             ser_r,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             busy
);
  localparam int KW = $clog2(WIDTH);
  localparam int GW = GAP > 0 ? $clog2(GAP + 1) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(WIDTH - 1);
  localparam logic [KW-1:0] K_PEN = KW'(WIDTH - 2);
  localparam logic [GW-1:0] G_LAST = GW'(GAP > 0 ? GAP - 1 : 0);
  typedef enum logic [1:0] {IDLE, SHIFT, GAPWAIT} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] sh, sh_n;
  logic [KW-1:0] k, k_n;
  logic [GW-1:0] g, g_n;
  logic i_n, r_n, v_n, l_n, accept, last_bit, gap_end;
  assign last_bit = state == SHIFT && k == K_LAST;
  assign gap_end = state == GAPWAIT && g == G_LAST;
  assign in_ready = state == IDLE || (GAP == 0 ? last_bit : gap_end);
  assign accept = in_valid && in_ready;
  assign busy = state != IDLE;
  // next state and the next values of the registered serial outputs
  always_comb begin
    state_n = state;
    sh_n = sh;
    k_n = k;
    g_n = g;
    i_n = 1'b0;
    r_n = 1'b0;
    v_n = 1'b0;
    l_n = 1'b0;
    if (accept) begin
      state_n = SHIFT;
      sh_n = in_data >> 1;
      k_n = '0;
      g_n = '0;
      i_n = in_data[0];
      r_n = 1'b1;
      v_n = 1'b1;
    end else if (state == SHIFT && !last_bit) begin
      sh_n = sh >> 1;
      k_n = k + 1'b1;
      i_n = sh[0];
      v_n = 1'b1;
      l_n = k == K_PEN;
    end else if (last_bit) begin
      state_n = GAP > 0 ? GAPWAIT : IDLE;
      k_n = '0;
      g_n = '0;
    end else if (state == GAPWAIT) begin
      state_n = gap_end ? IDLE : GAPWAIT;
      g_n = gap_end ? '0 : g + 1'b1;
    end
  end
  // state and output registers; reset drops any in-flight word
  always_ff @(posedge t_clk) begin
    if (!rst_n) begin
      state <= IDLE;
      sh <= '0;
      k <= '0;
      g <= '0;
      ser_i <= 1'b0;
      ser_r <= 1'b0;
      ser_valid <= 1'b0;
      ser_last <= 1'b0;
    end else begin
      state <= state_n;
      sh <= sh_n;
      k <= k_n;
      g <= g_n;
      ser_i <= i_n;
      ser_r <= r_n;
      ser_valid <= v_n;
      ser_last <= l_n;
    end
  end
endmodule

// File: doc/serial_word_tx.md
Name: serial_word_tx

Overview:
Parallel-to-serial transmitter that feeds the bit-serial two's-complement negator. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out LSB-first, one bit per t_clk. A first-bit marker (ser_r) is high only during bit 0 of each word, which is the frame-start convention the negator uses to clear its "seen a one" state. It sits immediately upstream of the negator; its ser_i/ser_r outputs drive the negator's i/r inputs directly.

Parameters:
WIDTH, 8, word length in bits (>=2)
GAP, 0, idle cycles inserted between consecutive words (0 = back-to-back streaming)

Ports:
t_clk  input  1  clock; all state changes on the rising edge
rst_n  input  1  synchronous active-low reset, sampled on the rising edge of t_clk
in_data  input  WIDTH  word to transmit, two's complement
in_valid  input  1  in_data is valid
in_ready  output  1  block can accept a word this cycle
ser_i  output  1  serial data bit, LSB first; drives the negator i input
ser_r  output  1  first-bit marker, high during bit 0 only; drives the negator r input
ser_valid  output  1  ser_i carries a live bit this cycle
ser_last  output  1  high during bit WIDTH-1 only
busy  output  1  high in SHIFT or GAPWAIT

Behaviour:
- Reset (rst_n=0 at a rising edge): state=IDLE; shift register, bit counter and gap counter cleared; ser_i=ser_r=ser_valid=ser_last=busy=0. Any in-flight word is dropped with no partial flush. Reset takes priority over every other event.
- All serial outputs are registered. Accept = in_valid & in_ready at a rising edge.
- in_ready (combinational from state): 1 in IDLE; 1 in SHIFT on bit WIDTH-1 when GAP=0; 1 in GAPWAIT on the final gap cycle when GAP>0; 0 otherwise.
- IDLE: serial outputs 0.
  - Accept -> SHIFT. The next cycle presents bit 0: ser_i=in_data[0], ser_r=1, ser_valid=1.
- SHIFT: bit counter k runs 0..WIDTH-1.
  - ser_i = word[k]; ser_r = (k==0); ser_last = (k==WIDTH-1).
  - On k=WIDTH-1 with GAP=0: if accept, the next cycle is bit 0 of the new word (ser_r=1), with no bubble. Otherwise -> IDLE.
  - On k=WIDTH-1 with GAP>0: -> GAPWAIT.
- GAPWAIT: ser_valid=ser_i=ser_r=0 for exactly GAP cycles.
  - On the final gap cycle: accept -> SHIFT bit 0 next cycle; else -> IDLE.
- Latency: accept at edge n -> bit 0 visible after edge n; bit j visible after edge n+j; ser_last after edge n+WIDTH-1.
- Word throughput: one word every WIDTH+GAP cycles.
- in_data is captured at accept; later changes have no effect on the word being sent.
- in_valid while in_ready=0 is ignored. The upstream must hold the word; the block never drops an offered word.
- ser_i=0 whenever ser_valid=0. ser_r is never high when ser_valid=0.
- Counters are sized clog2(WIDTH) and clog2(GAP+1) and wrap only by explicit reload, never by overflow.

Test Plan:
1. WIDTH=8, GAP=0: reset low 2 cycles -> all outputs 0, in_ready=1, busy=0. Release reset, offer 0x06 -> ser_i sequence 0,1,1,0,0,0,0,0 with ser_r=1 on the first bit only and ser_last on the 8th. Through the negator, the collected output is 0xFA.
2. Back-to-back, GAP=0: offer 0x01 then 0x80 with in_valid held high -> 16 consecutive valid bits, no bubble. ser_r pulses at bits 0 and 8. Negated results are 0xFF and 0x80.
3. GAP=2: two words offered continuously -> exactly 2 cycles with ser_valid=0 between ser_last and the next ser_r. in_ready is high only in IDLE and on the second gap cycle.
4. Backpressure: assert in_valid with 0x55 mid-word -> not accepted until in_ready. The word is sent intact after the current word, and nothing is lost or duplicated.
5. Reset mid-operation: send 0xF0, drive rst_n=0 at bit 3 -> next cycle all outputs 0, state IDLE. After release, 0x0F is sent cleanly with ser_r=1 on its first bit.
6. Word 0x00: all bits 0, ser_r on bit 0 -> negator output 0x00. Changing in_data after accept does not alter the bits being transmitted.
